// File: rtl/axis2fib_txctrl_gen_if.sv
// User-side AXI4-Stream TX bus feeding axis2fib_txctrl_gen.
// master drives the beat, slave (the controller) returns tready.
interface axis2fib_txctrl_gen_if #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
);
    logic [DATA_WIDTH-1:0] tx_axis_mac_tdata;
    logic [KEEP_WIDTH-1:0] tx_axis_mac_tkeep;
    logic                  tx_axis_mac_tvalid;
    logic                  tx_axis_mac_tlast;
    logic                  tx_axis_mac_tuser;
    logic                  tx_axis_mac_tready;

    modport master (
        output tx_axis_mac_tdata, tx_axis_mac_tkeep, tx_axis_mac_tvalid,
               tx_axis_mac_tlast, tx_axis_mac_tuser,
        input  tx_axis_mac_tready
    );

    modport slave (
        input  tx_axis_mac_tdata, tx_axis_mac_tkeep, tx_axis_mac_tvalid,
               tx_axis_mac_tlast, tx_axis_mac_tuser,
        output tx_axis_mac_tready
    );
endinterface

// File: rtl/axis2fib_txctrl_gen.sv
// TX ingress controller: AXI4-Stream frames -> bridge TX data FIFO plus one wbcnt word per frame.
// Optional per-frame statistics output enabled by defining AXIS2FIB_TXSTATS_EN.
module axis2fib_txctrl_gen #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int BCNT_WIDTH = 32,
    parameter int DATA_PTR   = 8,
    parameter int DATA_DEPTH = 512,
    parameter int MAX_BYTES  = 1518
) (
    input  logic                  tx_mac_aclk,
    input  logic                  reset,
    axis2fib_txctrl_gen_if.slave  axis,
    output logic [DATA_WIDTH-1:0] wr2_txdata_fifo,
    output logic                  txdata_wrreq,
    input  logic                  txdata_wrfull,
    input  logic [DATA_PTR:0]     txdata_wrusedw,
    output logic [BCNT_WIDTH-1:0] wr2_txwbcnt_fifo,
    output logic                  txwbcnt_wrreq,
    input  logic                  txwbcnt_wrfull,
    output logic                  bcnt_oversize,
    output logic [31:0]           tx_statistics_vector,
    output logic                  tx_statistics_valid
);
    localparam int MAX_BEATS = (MAX_BYTES + KEEP_WIDTH - 1) / KEEP_WIDTH;
    localparam int BEAT_W    = $clog2(MAX_BEATS + 1);
    localparam int POP_W     = $clog2(KEEP_WIDTH + 1);
    // Room for a whole worst-case frame plus 2 words of wrusedw lag.
    localparam logic [31:0] SPACE_LIMIT = 32'(DATA_DEPTH - MAX_BEATS - 2);

    localparam logic [3:0] S_IDLE    = 4'b0001;
    localparam logic [3:0] S_DATA    = 4'b0010;
    localparam logic [3:0] S_DISCARD = 4'b0100;
    localparam logic [3:0] S_BCNT    = 4'b1000;

    logic [3:0]            state;
    logic                  tready;
    logic [15:0]           bcnt;
    logic [BEAT_W-1:0]     beat_cnt;
    logic                  err_flag;
    logic                  ovs_flag;

    logic                  accept;
    logic [KEEP_WIDTH-1:0] keep;
    logic [POP_W-1:0]      keep_pop;
    logic                  keep_bad;
    logic                  space_ok;
    logic                  at_limit;
    logic                  wbcnt_fire;
    logic [BCNT_WIDTH-1:0] bcnt_word;

    assign axis.tx_axis_mac_tready = tready;
    assign accept   = tready & axis.tx_axis_mac_tvalid;
    assign space_ok = !txdata_wrfull && (32'(txdata_wrusedw) <= SPACE_LIMIT);
    assign at_limit = (beat_cnt == BEAT_W'(MAX_BEATS));
    // Second BCNT cycle (wrreq already high) is the one that leaves the state.
    assign wbcnt_fire = (state == S_BCNT) && !txwbcnt_wrreq && !txwbcnt_wrfull;

    always_comb begin
        keep     = axis.tx_axis_mac_tkeep;
        keep_pop = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            keep_pop = keep_pop + POP_W'(keep[i]);
        end
        // Legal tkeep is 2^n-1 with n>0, and all-ones unless on the last beat.
        keep_bad = (keep == '0) || ((keep & (keep + KEEP_WIDTH'(1))) != '0) ||
                   (!axis.tx_axis_mac_tlast && (keep != '1));
    end

    always_comb begin
        bcnt_word                 = '0;
        bcnt_word[BCNT_WIDTH-1]   = err_flag;
        bcnt_word[BCNT_WIDTH-2]   = ovs_flag;
        bcnt_word[15:0]           = bcnt;
    end

    always_ff @(posedge tx_mac_aclk) begin
        if (reset) begin
            state            <= S_IDLE;
            tready           <= 1'b0;
            bcnt             <= '0;
            beat_cnt         <= '0;
            err_flag         <= 1'b0;
            ovs_flag         <= 1'b0;
            wr2_txdata_fifo  <= '0;
            txdata_wrreq     <= 1'b0;
            wr2_txwbcnt_fifo <= '0;
            txwbcnt_wrreq    <= 1'b0;
            bcnt_oversize    <= 1'b0;
        end else begin
            txdata_wrreq  <= 1'b0;
            txwbcnt_wrreq <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (space_ok) begin
                        state  <= S_DATA;
                        tready <= 1'b1;
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        if (axis.tx_axis_mac_tuser || keep_bad) begin
                            err_flag <= 1'b1;
                        end
                        if (at_limit) begin
                            ovs_flag      <= 1'b1;
                            bcnt_oversize <= 1'b1;
                        end else begin
                            wr2_txdata_fifo <= axis.tx_axis_mac_tdata;
                            txdata_wrreq    <= 1'b1;
                            bcnt            <= bcnt + 16'(keep_pop);
                            beat_cnt        <= beat_cnt + BEAT_W'(1);
                        end
                        if (axis.tx_axis_mac_tlast) begin
                            state  <= S_BCNT;
                            tready <= 1'b0;
                        end else if (at_limit) begin
                            state <= S_DISCARD;
                        end
                    end
                end
                S_DISCARD: begin
                    if (accept) begin
                        if (axis.tx_axis_mac_tuser) begin
                            err_flag <= 1'b1;
                        end
                        if (axis.tx_axis_mac_tlast) begin
                            state  <= S_BCNT;
                            tready <= 1'b0;
                        end
                    end
                end
                S_BCNT: begin
                    if (txwbcnt_wrreq) begin
                        if (space_ok) begin
                            state  <= S_DATA;
                            tready <= 1'b1;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else if (wbcnt_fire) begin
                        wr2_txwbcnt_fifo <= bcnt_word;
                        txwbcnt_wrreq    <= 1'b1;
                        bcnt             <= '0;
                        beat_cnt         <= '0;
                        err_flag         <= 1'b0;
                        ovs_flag         <= 1'b0;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    tready <= 1'b0;
                end
            endcase
        end
    end

`ifdef AXIS2FIB_TXSTATS_EN
    logic [7:0] frame_cnt;

    always_ff @(posedge tx_mac_aclk) begin
        if (reset) begin
            frame_cnt            <= '0;
            tx_statistics_vector <= '0;
            tx_statistics_valid  <= 1'b0;
        end else begin
            tx_statistics_valid <= 1'b0;
            if (wbcnt_fire) begin
                tx_statistics_vector <= {err_flag, ovs_flag, 6'b0, frame_cnt, bcnt};
                tx_statistics_valid  <= 1'b1;
                frame_cnt            <= frame_cnt + 8'd1;
            end
        end
    end
`else
    assign tx_statistics_vector = '0;
    assign tx_statistics_valid  = 1'b0;
`endif
endmodule

// File: tb/tb_axis2fib_txctrl_gen.sv
// Directed bench for axis2fib_txctrl_gen: frame-level model plus per-cycle output compare.
module tb_axis2fib_txctrl_gen;
    localparam int MAX_BEATS = 190;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] wr2_txdata_fifo;
    logic        txdata_wrreq;
    logic        txdata_wrfull = 1'b0;
    logic [8:0]  txdata_wrusedw = 9'd0;
    logic [31:0] wr2_txwbcnt_fifo;
    logic        txwbcnt_wrreq;
    logic        txwbcnt_wrfull = 1'b0;
    logic        bcnt_oversize;
    logic [31:0] tx_statistics_vector;
    logic        tx_statistics_valid;

    axis2fib_txctrl_gen_if #(.DATA_WIDTH(64)) axis ();

    axis2fib_txctrl_gen dut (
        .tx_mac_aclk          (clk),
        .reset                (reset),
        .axis                 (axis),
        .wr2_txdata_fifo      (wr2_txdata_fifo),
        .txdata_wrreq         (txdata_wrreq),
        .txdata_wrfull        (txdata_wrfull),
        .txdata_wrusedw       (txdata_wrusedw),
        .wr2_txwbcnt_fifo     (wr2_txwbcnt_fifo),
        .txwbcnt_wrreq        (txwbcnt_wrreq),
        .txwbcnt_wrfull       (txwbcnt_wrfull),
        .bcnt_oversize        (bcnt_oversize),
        .tx_statistics_vector (tx_statistics_vector),
        .tx_statistics_valid  (tx_statistics_valid)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [63:0] exp_data[$];
    logic [31:0] exp_wb[$];
    int          m_beats = 0, m_bytes = 0;
    bit          m_err = 0, m_ovs = 0;
    int          data_seen = 0, wb_seen = 0, last_wb_cyc = 0, frames_out = 0;
    int          tlast_cyc = 0, ready_cyc = 0, first_ready_cyc = 0;
    logic [31:0] last_wb = '0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic fail(input string name, input string what);
        checks++;
        errors++;
        $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
    endtask

    // Frame-level model: first MAX_BEATS beats are written, the rest only flag oversize.
    task automatic model_beat(input logic [63:0] d, input logic [7:0] k, input logic u,
                              input logic l);
        logic [7:0] kp1;
        bit bad;
        kp1 = k + 8'd1;
        bad = (k == 8'd0) || ((k & kp1) != 8'd0) || (!l && k != 8'hFF);
        if (u) m_err = 1;
        if (m_beats < MAX_BEATS) begin
            exp_data.push_back(d);
            m_bytes += $countones(k);
            if (bad) m_err = 1;
        end else begin
            if (m_beats == MAX_BEATS && bad) m_err = 1;
            m_ovs = 1;
        end
        m_beats++;
        if (l) begin
            exp_wb.push_back({m_err, m_ovs, 14'b0, 16'(m_bytes)});
            m_beats = 0; m_bytes = 0; m_err = 0; m_ovs = 0;
        end
    endtask

    always @(negedge clk) begin
        logic [31:0] w;
        if (txdata_wrreq) begin
            chk("txdata_wrreq_while_full", 64'(txdata_wrfull), 64'd0);
            data_seen++;
            if (exp_data.size() == 0) fail("txdata_unexpected", "data write with none expected");
            else chk("txdata_word", wr2_txdata_fifo, exp_data.pop_front());
        end
        if (txwbcnt_wrreq) begin
            wb_seen++;
            last_wb = wr2_txwbcnt_fifo;
            last_wb_cyc = cyc;
            chk("wbcnt_latency_ge2", 64'(cyc - tlast_cyc >= 2), 64'd1);
            if (exp_wb.size() == 0) begin
                fail("wbcnt_unexpected", "wbcnt write with none expected");
            end else begin
                w = exp_wb.pop_front();
                chk("wbcnt_word", wr2_txwbcnt_fifo, w);
`ifdef AXIS2FIB_TXSTATS_EN
                chk("stats_vector", tx_statistics_vector,
                    {w[31], w[30], 6'b0, 8'(frames_out), w[15:0]});
`endif
            end
            frames_out++;
        end
`ifdef AXIS2FIB_TXSTATS_EN
        chk("stats_valid_align", 64'(tx_statistics_valid), 64'(txwbcnt_wrreq));
`else
        chk("stats_valid_off", 64'(tx_statistics_valid), 64'd0);
        chk("stats_vector_off", tx_statistics_vector, 64'd0);
`endif
    end

    task automatic drive_beat(input logic [63:0] d, input logic [7:0] k, input logic u,
                              input logic l);
        int guard = 0;
        axis.tx_axis_mac_tvalid = 1'b1;
        axis.tx_axis_mac_tdata  = d;
        axis.tx_axis_mac_tkeep  = k;
        axis.tx_axis_mac_tuser  = u;
        axis.tx_axis_mac_tlast  = l;
        while (!axis.tx_axis_mac_tready && guard < 1000) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!axis.tx_axis_mac_tready) begin
            $display("FAIL tready_timeout: tready low for 1000 cycles");
            $fatal(1, "bench stopped");
        end
        ready_cyc = cyc;
        if (l) tlast_cyc = cyc;
        @(posedge clk); #1;
        model_beat(d, k, u, l);
        if (l) chk("tready_low_after_tlast", 64'(axis.tx_axis_mac_tready), 64'd0);
    endtask

    task automatic send_frame(input int f, input int n, input logic [7:0] lk, input logic lu);
        for (int i = 0; i < n; i++) begin
            drive_beat({32'(f), 32'(i)}, (i == n - 1) ? lk : 8'hFF,
                       (i == n - 1) ? lu : 1'b0, i == n - 1);
            if (i == 0) first_ready_cyc = ready_cyc;
        end
    endtask

    task automatic idle(input int n);
        axis.tx_axis_mac_tvalid = 1'b0;
        axis.tx_axis_mac_tlast  = 1'b0;
        axis.tx_axis_mac_tuser  = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_tready"}, 64'(axis.tx_axis_mac_tready), 64'd0);
        chk({tag, "_txdata_wrreq"}, 64'(txdata_wrreq), 64'd0);
        chk({tag, "_txwbcnt_wrreq"}, 64'(txwbcnt_wrreq), 64'd0);
        chk({tag, "_txdata_word"}, wr2_txdata_fifo, 64'd0);
        chk({tag, "_wbcnt_word"}, 64'(wr2_txwbcnt_fifo), 64'd0);
        chk({tag, "_oversize"}, 64'(bcnt_oversize), 64'd0);
        chk({tag, "_stats"}, {31'd0, tx_statistics_valid, tx_statistics_vector}, 64'd0);
    endtask

    initial begin
        int d0, w0, fall_cyc, t1;
        axis.tx_axis_mac_tvalid = 1'b0;
        axis.tx_axis_mac_tdata  = '0;
        axis.tx_axis_mac_tkeep  = '0;
        axis.tx_axis_mac_tlast  = 1'b0;
        axis.tx_axis_mac_tuser  = 1'b0;
        txdata_wrusedw = 9'd321;
        repeat (3) begin @(posedge clk); #1; end
        check_reset_outputs("reset");
        reset = 1'b0;

        // Space threshold: 321 used words is one too many, 320 is just enough.
        repeat (5) begin
            @(posedge clk); #1;
            chk("no_space_tready", 64'(axis.tx_axis_mac_tready), 64'd0);
        end
        txdata_wrusedw = 9'd320;
        @(posedge clk); #1;
        chk("space_ok_tready", 64'(axis.tx_axis_mac_tready), 64'd1);
        txdata_wrusedw = 9'd0;

        d0 = data_seen;
        send_frame(1, 8, 8'hFF, 1'b0);
        idle(6);
        chk("f64_writes", 64'(data_seen - d0), 64'd8);
        chk("f64_wbcnt", 64'(last_wb), 64'h40);

        d0 = data_seen;
        send_frame(2, 8, 8'h1F, 1'b0);
        idle(6);
        chk("f61_writes", 64'(data_seen - d0), 64'd8);
        chk("f61_wbcnt", 64'(last_wb), 64'h3D);
        chk("oversize_clear_before", 64'(bcnt_oversize), 64'd0);

        d0 = data_seen;
        send_frame(3, 250, 8'hFF, 1'b0);
        idle(6);
        chk("f2000_writes", 64'(data_seen - d0), 64'd190);
        chk("f2000_wbcnt", 64'(last_wb), 64'h400005F0);
        chk("oversize_sticky", 64'(bcnt_oversize), 64'd1);

        send_frame(4, 2, 8'hFF, 1'b1);
        idle(6);
        chk("tuser_wbcnt", 64'(last_wb), 64'h80000010);

        send_frame(5, 2, 8'h05, 1'b0);
        idle(6);
        chk("bad_keep_wbcnt", 64'(last_wb), 64'h8000000A);
        chk("oversize_still_set", 64'(bcnt_oversize), 64'd1);

        // wbcnt FIFO full across the end of a frame.
        w0 = wb_seen;
        txwbcnt_wrfull = 1'b1;
        send_frame(6, 2, 8'hFF, 1'b0);
        axis.tx_axis_mac_tvalid = 1'b0;
        repeat (10) begin
            chk("full_hold_tready", 64'(axis.tx_axis_mac_tready), 64'd0);
            chk("full_hold_no_write", 64'(wb_seen - w0), 64'd0);
            @(posedge clk); #1;
        end
        fall_cyc = cyc;
        txwbcnt_wrfull = 1'b0;
        idle(5);
        chk("full_one_write", 64'(wb_seen - w0), 64'd1);
        chk("full_write_cycle", 64'(last_wb_cyc - fall_cyc), 64'd1);
        chk("full_wbcnt", 64'(last_wb), 64'h10);

        // Back to back with tvalid held high, then reset on beat 4 of a third frame.
        w0 = wb_seen;
        send_frame(7, 8, 8'hFF, 1'b0);
        t1 = tlast_cyc;
        send_frame(8, 8, 8'hFF, 1'b0);
        chk("b2b_tready_gap", 64'(first_ready_cyc - t1), 64'd3);
        for (int i = 0; i < 3; i++) drive_beat({32'd9, 32'(i)}, 8'hFF, 1'b0, 1'b0);
        chk("b2b_two_writes", 64'(wb_seen - w0), 64'd2);
        chk("b2b_wbcnt", 64'(last_wb), 64'h40);
        axis.tx_axis_mac_tdata = {32'd9, 32'd3};
        chk("beat4_tready", 64'(axis.tx_axis_mac_tready), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("midreset");
        reset = 1'b0;
        m_beats = 0; m_bytes = 0; m_err = 0; m_ovs = 0;
        frames_out = 0;
        w0 = wb_seen;
        idle(20);
        chk("midreset_no_wbcnt", 64'(wb_seen - w0), 64'd0);
        chk("data_queue_drained", 64'(exp_data.size()), 64'd0);
        chk("wbcnt_queue_drained", 64'(exp_wb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
